// File: rtl/glyph_pkg.sv
// Shared glyph codes, FSM state encoding and shape constants for the
// cell glyph renderer.
package glyph_pkg;

  typedef enum logic [1:0] {
    GLYPH_NONE   = 2'd0,
    GLYPH_O      = 2'd1,
    GLYPH_X      = 2'd2,
    GLYPH_CURSOR = 2'd3
  } glyph_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_SHOWN  = 2'd2
  } state_t;

  localparam int CURSOR_W = 2;

  function automatic logic is_stroked(input glyph_t g);
    return (g == GLYPH_O) || (g == GLYPH_X);
  endfunction

endpackage

// File: rtl/glyph_shape.sv
// Combinational glyph rasteriser: decides whether glyph-relative pixel (h, v)
// is lit for the given shape, ignoring reveal and blink.
module glyph_shape
  import glyph_pkg::*;
#(
  parameter int CW    = 11,
  parameter int SIZE  = 101,
  parameter int THICK = 11
) (
  input  logic [CW-1:0] h_i,
  input  logic [CW-1:0] v_i,
  input  glyph_t        glyph_i,
  output logic          lit_o
);

  localparam logic [CW-1:0] SIZE_C    = CW'(SIZE);
  localparam logic [CW-1:0] THICK_C   = CW'(THICK);
  localparam logic [CW-1:0] FAR_C     = CW'(SIZE - THICK);
  localparam logic [CW-1:0] CUR_W_C   = CW'(CURSOR_W);
  localparam logic [CW-1:0] CUR_FAR_C = CW'(SIZE - CURSOR_W);
  localparam logic [CW:0]   THICK_W_C = (CW+1)'(THICK);
  localparam logic [CW:0]   DIAG_C    = (CW+1)'(SIZE - 1);

  logic          inside_s;
  logic          shape_s;
  logic [CW:0]   diff_s;
  logic [CW:0]   anti_s;
  logic [CW:0]   diff_abs_s;
  logic [CW:0]   anti_abs_s;

  // Shape decode; the diagonals use one extra bit so signed distances survive
  always_comb begin
    inside_s   = (h_i < SIZE_C) && (v_i < SIZE_C);
    diff_s     = {1'b0, h_i} - {1'b0, v_i};
    anti_s     = {1'b0, h_i} + {1'b0, v_i} - DIAG_C;
    diff_abs_s = diff_s[CW] ? (~diff_s + (CW+1)'(1)) : diff_s;
    anti_abs_s = anti_s[CW] ? (~anti_s + (CW+1)'(1)) : anti_s;
    case (glyph_i)
      GLYPH_O:      shape_s = (h_i < THICK_C) || (h_i >= FAR_C) ||
                              (v_i < THICK_C) || (v_i >= FAR_C);
      GLYPH_X:      shape_s = (diff_abs_s < THICK_W_C) || (anti_abs_s < THICK_W_C);
      GLYPH_CURSOR: shape_s = (h_i < CUR_W_C) || (h_i >= CUR_FAR_C) ||
                              (v_i < CUR_W_C) || (v_i >= CUR_FAR_C);
      default:      shape_s = 1'b0;
    endcase
    lit_o = inside_s && shape_s;
  end

endmodule

// File: rtl/cell_glyph.sv
// Per-cell glyph renderer: frame-synchronous reveal/blink FSM feeding a
// two-stage pixel pipeline (offset subtract, then shape and mask).
module cell_glyph
  import glyph_pkg::*;
#(
  parameter int CW        = 11,
  parameter int SIZE      = 101,
  parameter int THICK     = 11,
  parameter int HOFF      = 59,
  parameter int VOFF      = 20,
  parameter int REVEAL_FR = 8,
  parameter int BLINK_FR  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  input  logic [CW-1:0] hmin,
  input  logic [CW-1:0] vmin,
  input  logic          frame_start,
  input  logic [1:0]    glyph,
  input  logic          win,
  output logic          out,
  output logic          busy
);

  localparam int RW = $clog2(REVEAL_FR + 1);
  localparam int BW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  localparam logic [CW-1:0] HOFF_C = CW'(HOFF);
  localparam logic [CW-1:0] VOFF_C = CW'(VOFF);
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0] QSTEP  = CW'(SIZE / REVEAL_FR);
  localparam logic [CW-1:0] RSTEP  = CW'(SIZE % REVEAL_FR);
  localparam logic [CW:0]   RDIV   = (CW+1)'(REVEAL_FR);
  localparam logic [RW-1:0] RLAST  = RW'(REVEAL_FR);
  localparam logic [BW-1:0] BLAST  = BW'(BLINK_FR - 1);

  state_t        state_q, state_d;
  glyph_t        glyph_q, glyph_d;
  logic          win_q, win_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] quo_q, quo_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blank_q, blank_d;
  glyph_t        glyph_in_s;
  logic [CW:0]   rem_sum_s;

  logic [CW-1:0] h1_q, h1_d;
  logic [CW-1:0] v1_q, v1_d;
  logic [CW-1:0] lim1_q, lim1_d;
  glyph_t        g1_q, g1_d;
  logic          out_q, out_d;
  logic          lit_s;

  // Frame-rate state: FSM, reveal count with its quotient/remainder accumulator, blink
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      glyph_q <= GLYPH_NONE;
      win_q   <= 1'b0;
      rcnt_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      bcnt_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      glyph_q <= glyph_d;
      win_q   <= win_d;
      rcnt_q  <= rcnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
    end
  end

  // Next-state logic; {quo,rem} tracks rcnt*SIZE/REVEAL_FR so no divider is needed
  always_comb begin
    state_d    = state_q;
    glyph_d    = glyph_q;
    win_d      = win_q;
    rcnt_d     = rcnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    bcnt_d     = bcnt_q;
    blank_d    = blank_q;
    glyph_in_s = glyph_t'(glyph);
    rem_sum_s  = {1'b0, rem_q} + {1'b0, RSTEP};
    if (frame_start) begin
      glyph_d = glyph_in_s;
      win_d   = win;
      if (glyph_in_s == GLYPH_NONE) begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
        quo_d   = '0;
        rem_d   = '0;
        bcnt_d  = '0;
        blank_d = 1'b0;
      end else if ((state_q == ST_IDLE) || (glyph_in_s != glyph_q)) begin
        bcnt_d  = '0;
        blank_d = 1'b0;
        if (is_stroked(glyph_in_s)) begin
          state_d = (REVEAL_FR > 1) ? ST_REVEAL : ST_SHOWN;
          rcnt_d  = RW'(1);
          quo_d   = QSTEP;
          rem_d   = RSTEP;
        end else begin
          state_d = ST_SHOWN;
          rcnt_d  = '0;
          quo_d   = '0;
          rem_d   = '0;
        end
      end else begin
        case (state_q)
          ST_REVEAL: begin
            rcnt_d = rcnt_q + RW'(1);
            if (rem_sum_s >= RDIV) begin
              rem_d = CW'(rem_sum_s - RDIV);
              quo_d = quo_q + QSTEP + CW'(1);
            end else begin
              rem_d = rem_sum_s[CW-1:0];
              quo_d = quo_q + QSTEP;
            end
            if ((rcnt_q + RW'(1)) >= RLAST) begin
              state_d = ST_SHOWN;
            end else begin
              state_d = ST_REVEAL;
            end
          end
          ST_SHOWN: begin
            if (!win) begin
              bcnt_d  = '0;
              blank_d = 1'b0;
            end else if (bcnt_q == BLAST) begin
              bcnt_d  = '0;
              blank_d = !blank_q;
            end else begin
              bcnt_d  = bcnt_q + BW'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Status output
  always_comb begin
    busy = (state_q == ST_REVEAL);
    out  = out_q;
  end

  // Stage 1 inputs; control context travels with the pixel so it sees pre-update state
  always_comb begin
    h1_d = hcount - hmin - HOFF_C;
    v1_d = vcount - vmin - VOFF_C;
    if (state_q == ST_REVEAL) begin
      lim1_d = quo_q + {{(CW-1){1'b0}}, (rem_q != '0)};
    end else begin
      lim1_d = SIZE_C;
    end
    if (blank_q && win_q) begin
      g1_d = GLYPH_NONE;
    end else begin
      g1_d = glyph_q;
    end
  end

  glyph_shape #(
    .CW   (CW),
    .SIZE (SIZE),
    .THICK(THICK)
  ) u_shape (
    .h_i    (h1_q),
    .v_i    (v1_q),
    .glyph_i(g1_q),
    .lit_o  (lit_s)
  );

  // Stage 2 result: shape gated by the reveal line limit
  always_comb begin
    out_d = lit_s && (v1_q < lim1_q);
  end

  // Pixel pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q   <= '0;
      v1_q   <= '0;
      lim1_q <= '0;
      g1_q   <= GLYPH_NONE;
      out_q  <= 1'b0;
    end else begin
      h1_q   <= h1_d;
      v1_q   <= v1_d;
      lim1_q <= lim1_d;
      g1_q   <= g1_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: tb/tb_cell_glyph.sv
// Directed bench for cell_glyph with default parameters: reveal, shapes,
// blink, offsets/wraparound, latency and asynchronous reset.
module tb_cell_glyph;

  logic        clk;
  logic        rst_n;
  logic [10:0] hcount, vcount, hmin, vmin;
  logic        frame_start;
  logic [1:0]  glyph;
  logic        win;
  logic        out;
  logic        busy;

  int errors = 0;
  int checks = 0;

  cell_glyph dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hcount     (hcount),
    .vcount     (vcount),
    .hmin       (hmin),
    .vmin       (vmin),
    .frame_start(frame_start),
    .glyph      (glyph),
    .win        (win),
    .out        (out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic probe(input int h, input int v, input logic exp, input string tag);
    hcount = h[10:0];
    vcount = v[10:0];
    tick();
    tick();
    check(tag, out, exp);
  endtask

  initial begin
    rst_n = 1'b1; hcount = 11'd0; vcount = 11'd0; hmin = 11'd0; vmin = 11'd0;
    frame_start = 1'b0; glyph = 2'd0; win = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", out, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // O reveal: after 4 frames the limit is ceil(4*101/8) = 51 lines
    glyph = 2'd1;
    repeat (4) frame();
    check("rev4_busy", busy, 1'b1);
    probe(59, 70, 1'b1, "rev4_v50");
    probe(59, 71, 1'b0, "rev4_v51");
    probe(159, 70, 1'b1, "rev4_right");
    probe(109, 30, 1'b1, "rev4_top");

    // Pixel coinciding with frame_start uses the old limit (51), the next one the new (64)
    hcount = 11'd59; vcount = 11'd71; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("coinc_pre", out, 1'b0);
    tick();
    check("coinc_post", out, 1'b1);

    repeat (2) frame();
    check("rev7_busy", busy, 1'b1);
    frame();
    check("rev8_busy", busy, 1'b0);
    frame();
    probe(59, 20, 1'b1, "o_corner_tl");
    probe(159, 120, 1'b1, "o_corner_br");
    probe(109, 70, 1'b0, "o_center");
    probe(58, 20, 1'b0, "o_left_out");
    probe(160, 20, 1'b0, "o_right_out");

    // Blink: blank toggles every 16th counted frame
    win = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      frame();
      probe(59, 20, ((k / 16) % 2) == 0, $sformatf("blink_%0d", k));
    end
    win = 1'b0;
    probe(59, 20, 1'b0, "win_midframe");
    frame();
    probe(59, 20, 1'b1, "win_clear");
    win = 1'b1;
    frame(); frame();
    probe(59, 20, 1'b1, "win_restart");
    win = 1'b0;

    // X: change from O restarts the reveal
    glyph = 2'd2;
    frame();
    check("x_restart_busy", busy, 1'b1);
    repeat (7) frame();
    check("x_shown_busy", busy, 1'b0);
    hmin = 11'd200;
    hcount = 11'd309; vcount = 11'd70;
    tick(); tick();
    check("x_center", out, 1'b1);
    vcount = 11'd20;
    tick();
    check("x_lat1", out, 1'b1);
    tick();
    check("x_lat2", out, 1'b0);
    probe(359, 20, 1'b1, "x_anti");
    probe(309, 30, 1'b0, "x_gap");
    hmin = 11'd300;
    probe(10, 70, 1'b0, "wrap");

    // CURSOR: 2-pixel frame, shown without reveal
    hmin = 11'd0;
    glyph = 2'd3;
    frame();
    check("cur_busy", busy, 1'b0);
    probe(60, 21, 1'b1, "cur_edge");
    probe(61, 22, 1'b0, "cur_inner");
    probe(159, 70, 1'b1, "cur_right");
    probe(157, 70, 1'b0, "cur_right_in");

    glyph = 2'd0;
    frame();
    probe(60, 21, 1'b0, "none_dark");
    check("none_busy", busy, 1'b0);

    // Reset mid-reveal
    glyph = 2'd1;
    repeat (3) frame();
    check("rev3_busy", busy, 1'b1);
    probe(59, 20, 1'b1, "rev3_lit");
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", out, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    check("post_rst_busy", busy, 1'b0);
    probe(59, 20, 1'b0, "post_rst_idle");
    frame();
    check("restart_busy", busy, 1'b1);
    probe(59, 32, 1'b1, "restart_v12");
    probe(59, 33, 1'b0, "restart_v13");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
